// File: rtl/downcount_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit down counter between two requesters.
// The winner loads its start value, counts to zero, and gets a one-cycle done pulse.
module downcount_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] len0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] q,
  output logic             done0,
  output logic             done1,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_last, w_last_nxt;   // 1: requester 1 was granted most recently
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_gnt0, w_gnt0_nxt;
  logic             r_gnt1, w_gnt1_nxt;
  logic             r_done0, w_done0_nxt;
  logic             r_done1, w_done1_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_pick1;
  logic             w_own_req;

  // On contention, pick requester 1 only when requester 0 was served last.
  assign w_pick1   = req1 & (~req0 | ~r_last);
  assign w_own_req = r_gnt1 ? req1 : req0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_q     <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_q     <= w_q_nxt;
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_q_nxt     = r_q;
    w_gnt0_nxt  = r_gnt0;
    w_gnt1_nxt  = r_gnt1;
    w_done0_nxt = 1'b0;
    w_done1_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_state_nxt = S_COUNT;
          w_last_nxt  = w_pick1;
          w_gnt0_nxt  = ~w_pick1;
          w_gnt1_nxt  = w_pick1;
          w_q_nxt     = w_pick1 ? len1 : len0;
        end
      end
      S_COUNT: begin
        if (!w_own_req) begin
          w_state_nxt = S_IDLE;
          w_gnt0_nxt  = 1'b0;
          w_gnt1_nxt  = 1'b0;
          w_q_nxt     = '0;
        end else if (r_q != '0) begin
          w_q_nxt = r_q - WIDTH'(1);
        end else begin
          w_state_nxt = S_DONE;
          w_done0_nxt = r_gnt0;
          w_done1_nxt = r_gnt1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign q     = r_q;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign busy  = r_busy;

endmodule

// File: tb/tb_downcount_arbiter.sv
// Directed bench for downcount_arbiter: expected outputs are hand-derived per cycle.
module tb_downcount_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [3:0] len0, len1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] q;

  int n_checks;
  int n_fails;

  downcount_arbiter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .len0  (len0),
    .req1  (req1),
    .len1  (len1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .q     (q),
    .done0 (done0),
    .done1 (done1),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic g0, input logic g1, input int qv,
                          input logic d0, input logic d1, input logic b);
    chk({tag, ".gnt0"},  32'(gnt0),  32'(g0));
    chk({tag, ".gnt1"},  32'(gnt1),  32'(g1));
    chk({tag, ".q"},     32'(q),     32'(qv));
    chk({tag, ".done0"}, 32'(done0), 32'(d0));
    chk({tag, ".done1"}, 32'(done1), 32'(d1));
    chk({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic g0, input logic g1, input int qv,
                      input logic d0, input logic d1, input logic b);
    tick();
    chk_outs(tag, g0, g1, qv, d0, d1, b);
  endtask

  // One full ownership: q walks len..0, then the DONE cycle with the done pulse.
  task automatic run_owner(input string tag, input int who, input int len);
    for (int v = len; v >= 0; v--)
      step({tag, ".cnt"}, who == 0, who == 1, v, 1'b0, 1'b0, 1'b1);
    step({tag, ".done"}, who == 0, who == 1, 0, who == 0, who == 1, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst  = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    len0 = '0;   len1 = '0;

    // Reset hold, then idle after release
    #1 chk_outs("rst_async", 0, 0, 0, 0, 0, 0);
    repeat (3) step("rst_hold", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (20) step("idle", 0, 0, 0, 0, 0, 0);

    // Single requester 0, len 5
    req0 = 1'b1; len0 = 4'd5;
    run_owner("r0_len5", 0, 5);
    req0 = 1'b0;
    step("r0_len5.after", 0, 0, 0, 0, 0, 0);

    // Fresh reset, then both held: order 0, 1, 0 with one idle cycle between
    rst = 1'b0; tick(); rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd3;
    run_owner("rr_a", 0, 2);
    step("rr_gap1", 0, 0, 0, 0, 0, 0);
    run_owner("rr_b", 1, 3);
    step("rr_gap2", 0, 0, 0, 0, 0, 0);
    run_owner("rr_c", 0, 2);
    req0 = 1'b0; req1 = 1'b0;
    step("rr_end", 0, 0, 0, 0, 0, 0);

    // len = 0 on requester 1
    req1 = 1'b1; len1 = 4'd0;
    run_owner("r1_len0", 1, 0);
    req1 = 1'b0;
    step("r1_len0.after", 0, 0, 0, 0, 0, 0);

    // Abort at q=6 with requester 1 pending; pointer (last=1) grants 0 first
    req0 = 1'b1; len0 = 4'd9; req1 = 1'b1; len1 = 4'd4;
    for (int v = 9; v >= 6; v--) step("abort.cnt", 1, 0, v, 0, 0, 1);
    req0 = 1'b0;
    step("abort.idle", 0, 0, 0, 0, 0, 0);
    step("abort.next", 0, 1, 4, 0, 0, 1);
    req1 = 1'b0;
    step("abort2.idle", 0, 0, 0, 0, 0, 0);

    // Reset mid-count at q=8; pointer restarts favouring requester 0
    req0 = 1'b1; len0 = 4'd15;
    for (int v = 15; v >= 8; v--) step("midrst.cnt", 1, 0, v, 0, 0, 1);
    #2 rst = 1'b0;
    #1 chk_outs("midrst.clear", 0, 0, 0, 0, 0, 0);
    req1 = 1'b1; len1 = 4'd7;
    step("midrst.hold", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step("midrst.regrant", 1, 0, 15, 0, 0, 1);
    req0 = 1'b0;
    step("midrst.abort", 0, 0, 0, 0, 0, 0);
    step("midrst.r1", 0, 1, 7, 0, 0, 1);
    req1 = 1'b0;
    step("midrst.end", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/downcount_arbiter.md
# downcount_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit binary down counter between two requesters. Each requester presents a start value; the winner owns the counter, which is loaded, decremented once per clock to zero, and reported back with a one-cycle done pulse before the counter is released. It sits between the timing clients and the down-counter datapath, replacing direct client control of the counter.

## Interface
- WIDTH, 4, counter and length width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 wants the counter; held high until done0 or to abort
- len0  input  WIDTH  requester 0 start value, sampled only in the cycle req0 is granted
- req1  input  1  requester 1 request, same rules as req0
- len1  input  WIDTH  requester 1 start value
- gnt0  output  1  counter owned by requester 0 (registered)
- gnt1  output  1  counter owned by requester 1 (registered)
- q  output  WIDTH  current counter value (registered)
- done0  output  1  one-cycle pulse: requester 0 count reached zero
- done1  output  1  one-cycle pulse: requester 1 count reached zero
- busy  output  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: no owner.
  - COUNT: counter running for the owner.
  - DONE: completion pulse.
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - q=0; gnt0, gnt1, done0, done1 and busy are all 0.
  - Round-robin pointer favours requester 0.
- IDLE with no request: stay in IDLE; q holds its last value.
- IDLE with one request: grant it.
- IDLE with both requests: grant the requester not served last. The pointer is updated on every grant, not on done.
- On grant:
  - Next state is COUNT.
  - q <= len of the winner; the winner's gnt goes to 1.
- COUNT, owner's req still high:
  - If q != 0: q <= q-1.
  - If q == 0: go to DONE; q stays 0.
- COUNT, owner's req low (abort):
  - Go to IDLE; gnt clears; q <= 0.
  - No done pulse; pointer keeps the aborted grant as last-served.
- DONE:
  - The owner's done pulses high for exactly one cycle and gnt stays high during that cycle.
  - Next state is IDLE regardless of req.
- len=0 is legal: one COUNT cycle with q=0, then DONE.
- No wrap-around: q never decrements below 0.
- A request held high after its done is treated as a new request in IDLE and competes under round-robin.
- The non-owner's req and len are ignored outside IDLE.
- At most one gnt and at most one done are high in any cycle.

## Timing
- Cycle k, IDLE, req sampled: at k+1, gnt=1, q=len, busy=1.
- q then reads len, len-1, …, 0 on consecutive cycles (len+1 COUNT cycles).
- DONE occupies cycle k+len+2, with the done pulse and gnt still high.
- At k+len+3: gnt=0, busy=0, state is IDLE, and a new grant can be decided in that cycle.
- Back-to-back grants therefore have one IDLE cycle between them; gnt is high for len+2 cycles.
- Abort: req low in a COUNT cycle gives gnt=0, q=0, busy=0 on the next edge.
- Reset mid-operation clears all outputs immediately and asynchronously. After release, the block restarts from IDLE with requester 0 favoured.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset hold then release with req0=req1=0 -> all outputs 0, busy=0 for 20 cycles.
- req0=1, len0=5 alone -> gnt0 next cycle; q=5,4,3,2,1,0; done0 pulse one cycle later; gnt0 high 7 cycles; busy falls after.
- req0 and req1 high from reset, len0=2, len1=3, both held -> order is 0, then 1, then 0 again. Each done precedes an IDLE gap of exactly one cycle; gnt0 and gnt1 are never both high.
- req1=1, len1=0 -> gnt1 with q=0 for one cycle, then done1 pulse, then IDLE (gnt1 high 2 cycles).
- req0=1, len0=9; drop req0 when q=6 -> next cycle gnt0=0, q=0, busy=0, done0 never pulses; a pending req1 is granted next.
- req0=1, len0=15, WIDTH=4; assert rst low when q=8 -> outputs cleared at once; after release, a simultaneous req0 and req1 grants requester 0 first.
